nfv_dc_sync_stable: RTL and testbench

NFV_DC_SYNC_STABLE -- requirements
Module: nfv_dc_sync_stable

---
 rtl/nfv_dc_sync_stable.sv | 90 +++++++++
 tb/tb_nfv_dc_sync_stable.sv | 130 +++++++++++++
 2 files changed

// File: rtl/nfv_dc_sync_stable.sv
// nfv_dc_sync_stable: multi-bit CDC synchroniser that only passes a value held steady for STABLE_CYCLES samples.
// Optional timeout/sticky error logic is enabled by defining NFV_DC_SYNC_STABLE_TIMEOUT_EN.
module nfv_dc_sync_stable #(
  parameter int               WIDTH          = 20,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter int               SYNC_STAGES    = 3,
  parameter int               STABLE_CYCLES  = 4,
  parameter int               TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] sync_out,
  output logic             upd_pulse,
  output logic             busy,
  input  logic             err_clr,
  output logic             unstable_err
);
  localparam int SS = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
  localparam int SC = (STABLE_CYCLES < 1) ? 1 : STABLE_CYCLES;
  localparam int TO = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int CW = $clog2(SC + 1);
  typedef enum logic {IDLE, QUAL} state_t;
  (* dont_merge, async_reg = "true" *) logic [WIDTH-1:0] chain_q [SS];
  logic [WIDTH-1:0] chain_d [SS];
  logic [WIDTH-1:0] s, h_q, h_d, sync_q, sync_d;
  logic [CW-1:0]    c_q, c_d;
  state_t           state_q, state_d;
  logic             upd_q, upd_d, busy_q, busy_d, eq, done;
  always_comb begin
    chain_d[0] = sig_in;
    for (int i = 1; i < SS; i++) chain_d[i] = chain_q[i-1];
    s       = chain_q[SS-1];
    eq      = (s == h_q);
    done    = (state_q == QUAL) && eq && (c_q == CW'(SC));
    h_d     = eq ? h_q : s;
    c_d     = !eq ? CW'(1) : (c_q == CW'(SC)) ? c_q : c_q + CW'(1);
    sync_d  = done ? h_q : sync_q;
    upd_d   = done;
    // QUAL simply means the held candidate differs from the published value
    state_d = (h_d != sync_d) ? QUAL : IDLE;
    busy_d  = (state_d == QUAL);
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      chain_q <= '{default: RESET_VALUE};
      h_q     <= RESET_VALUE;
      sync_q  <= RESET_VALUE;
      c_q     <= '0;
      state_q <= IDLE;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      h_q     <= h_d;
      sync_q  <= sync_d;
      c_q     <= c_d;
      state_q <= state_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
    end
  end
  assign sync_out  = sync_q;
  assign upd_pulse = upd_q;
  assign busy      = busy_q;
`ifdef NFV_DC_SYNC_STABLE_TIMEOUT_EN
  localparam int TW = $clog2(TO + 1);
  logic [TW-1:0] t_q, t_d;
  logic          err_q, err_d;
  always_comb begin
    t_d   = (state_q != QUAL) ? '0 : (t_q == TW'(TO)) ? t_q : t_q + TW'(1);
    // set fires only on the edge the limit is reached, so a later clear sticks
    err_d = ((t_q != TW'(TO)) && (t_d == TW'(TO))) || (err_q && !err_clr);
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      t_q   <= '0;
      err_q <= 1'b0;
    end else begin
      t_q   <= t_d;
      err_q <= err_d;
    end
  end
  assign unstable_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign unstable_err   = 1'b0;
`endif
endmodule

// File: tb/tb_nfv_dc_sync_stable.sv
// tb_nfv_dc_sync_stable: directed checks of the stable-value synchroniser, default and clamped configurations.
module tb_nfv_dc_sync_stable;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [19:0] sig = '0, sig2 = '0, sync_out, sync2;
  logic        upd, busy, err_clr = 1'b0, uerr, upd2, busy2, uerr2;
  int          n = 0, nerr = 0, pulses;
  logic [19:0] exp_sync;
  always #5 clk = ~clk;

  nfv_dc_sync_stable dut (
    .clk(clk), .arst_n(arst_n), .sig_in(sig), .sync_out(sync_out),
    .upd_pulse(upd), .busy(busy), .err_clr(err_clr), .unstable_err(uerr));

  nfv_dc_sync_stable #(.SYNC_STAGES(0), .STABLE_CYCLES(1)) u_clamp (
    .clk(clk), .arst_n(arst_n), .sig_in(sig2), .sync_out(sync2),
    .upd_pulse(upd2), .busy(busy2), .err_clr(1'b0), .unstable_err(uerr2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    cyc(2);
    chk("rst_sync", 32'(sync_out), 32'h0);
    chk("rst_upd", 32'(upd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(uerr), 32'h0);
    arst_n = 1'b1;
    cyc(3);
    chk("idle_sync", 32'(sync_out), 32'h0);
    // step to 0xABCDE: h loads at edge 4, publish at edge 8
    sig = 20'hABCDE;
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      chk($sformatf("step_sync_e%0d", k), 32'(sync_out), (k >= 8) ? 32'hABCDE : 32'h0);
      chk($sformatf("step_upd_e%0d", k), 32'(upd), 32'(k == 8));
      chk($sformatf("step_busy_e%0d", k), 32'(busy), 32'(k >= 4 && k <= 7));
    end
    // reset in the middle of qualifying 0x55555
    sig = 20'h55555;
    cyc(5);
    chk("midq_busy", 32'(busy), 32'h1);
    @(posedge clk); #2;
    arst_n = 1'b0;
    #1;
    chk("arst_sync", 32'(sync_out), 32'h0);
    chk("arst_upd", 32'(upd), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    sig = '0;
    cyc(2);
    arst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      pulses += int'(upd);
    end
    chk("post_rst_sync", 32'(sync_out), 32'h0);
    chk("post_rst_pulses", 32'(pulses), 32'h0);
    // 3-cycle glitch: QUAL after edges 4..6, rejected at edge 7
    sig = 20'h1;
    cyc(1);
    cyc(1);
    cyc(1);
    sig = 20'h0;
    chk("gl_busy_e3", 32'(busy), 32'h0);
    pulses = 0;
    for (int k = 4; k <= 10; k++) begin
      cyc(1);
      pulses += int'(upd);
      chk($sformatf("gl_busy_e%0d", k), 32'(busy), 32'(k <= 6));
    end
    chk("gl_sync", 32'(sync_out), 32'h0);
    chk("gl_pulses", 32'(pulses), 32'h0);
    // toggle 0x1/0x2 every 2 cycles for 300 cycles: never qualifies
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      sig = i[0] ? 20'h2 : 20'h1;
      cyc(1);
      pulses += int'(upd);
      cyc(1);
      pulses += int'(upd);
    end
    chk("tog_sync", 32'(sync_out), 32'h0);
    chk("tog_pulses", 32'(pulses), 32'h0);
    chk("tog_busy", 32'(busy), 32'h1);
`ifdef NFV_DC_SYNC_STABLE_TIMEOUT_EN
    chk("tog_err_set", 32'(uerr), 32'h1);
`else
    chk("tog_err_off", 32'(uerr), 32'h0);
`endif
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
    chk("tog_err_clr", 32'(uerr), 32'h0);
    sig = 20'h0;
    cyc(10);
    chk("tog_idle_busy", 32'(busy), 32'h0);
    chk("tog_idle_sync", 32'(sync_out), 32'h0);
    // back-to-back: 0x1 for 5 edges then 0x2; pulses at edges 8 and 13
    sig = 20'h1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 6) sig = 20'h2;
      cyc(1);
      exp_sync = (k < 8) ? 20'h0 : (k < 13) ? 20'h1 : 20'h2;
      chk($sformatf("b2b_sync_e%0d", k), 32'(sync_out), 32'(exp_sync));
      chk($sformatf("b2b_upd_e%0d", k), 32'(upd), 32'(k == 8 || k == 13));
    end
    // clamped instance: one stage, one stable sample -> edge 3
    sig2 = 20'h12345;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk($sformatf("clamp_sync_e%0d", k), 32'(sync2), (k >= 3) ? 32'h12345 : 32'h0);
      chk($sformatf("clamp_upd_e%0d", k), 32'(upd2), 32'(k == 3));
      chk($sformatf("clamp_busy_e%0d", k), 32'(busy2), 32'(k == 2));
    end
    chk("clamp_err", 32'(uerr2), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n, nerr);
    $finish;
  end
endmodule
